// File: rtl/obuf4_collect_pkg.sv
// Shared types and sizing for the 4x4 output de-skew buffer (obuf4_collect).
package obuf4_pkg;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 4;
    localparam int unsigned CW = 3;       // column counter holds 0..N
    localparam int unsigned RW = 2;       // row index width
    localparam int unsigned BW = N * DW;  // full row / lane bus width

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    function automatic logic [DW-1:0] lane(input logic [BW-1:0] bus, input int unsigned j);
        return bus[j*DW +: DW];
    endfunction

endpackage

// File: rtl/obuf4_collect_if.sv
// MAC-array result inputs and the row read port of obuf4_collect.
interface obuf4_collect_if;
    import obuf4_pkg::*;

    logic [BW-1:0] ODATA;
    logic [N-1:0]  OVALID;
    logic [TW-1:0] ODST_i;
    logic          RD_VALID;
    logic          RD_READY;
    logic [BW-1:0] RD_DATA;
    logic [RW-1:0] RD_ROW;
    logic [TW-1:0] ODST_o;
    logic          BUSY;
    logic          TILE_DONE;
    logic          ERR_OVF;

    modport master (
        output ODATA, OVALID, ODST_i, RD_READY,
        input  RD_VALID, RD_DATA, RD_ROW, ODST_o, BUSY, TILE_DONE, ERR_OVF
    );

    modport slave (
        input  ODATA, OVALID, ODST_i, RD_READY,
        output RD_VALID, RD_DATA, RD_ROW, ODST_o, BUSY, TILE_DONE, ERR_OVF
    );

endinterface

// File: rtl/obuf4_collect_col.sv
// Per-column capture unit: N-entry result column with write counter and overflow detect.
module obuf4_col
    import obuf4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          vld,
    input  logic [DW-1:0] din,
    input  logic [RW-1:0] rsel,
    output logic [DW-1:0] dout,
    output logic          full_nxt,
    output logic          ovf
);

    logic [DW-1:0] mem [N];
    logic [CW-1:0] cnt;
    logic [RW-1:0] wr_idx;
    logic          full;
    logic          take;

    // clr restarts the column at row 0 regardless of the stale full count
    assign full     = (cnt == CW'(N));
    assign take     = vld && en && (clr || !full);
    assign ovf      = vld && !take;
    assign full_nxt = full || (take && (cnt == CW'(N - 1)));
    assign wr_idx   = clr ? RW'(0) : cnt[RW-1:0];
    assign dout     = mem[rsel];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= take ? CW'(1) : '0;
        end else if (take) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/obuf4_collect.sv
// De-skews MAC-array column results into a 4x4 tile and drains it row by row.
// Build option OBUF_RELU_EN clamps negative lanes to zero on the read path.
module obuf4_collect
    import obuf4_pkg::*;
(
    input  logic            CLK,
    input  logic            RST,
    obuf4_collect_if.slave  bus
);

    state_t        state;
    logic [RW-1:0] rd_ptr;
    logic          rd_valid;
    logic          tile_done;
    logic          err_ovf;
    logic [TW-1:0] tag;

    logic [DW-1:0] row_lane [N];
    logic [N-1:0]  full_nxt;
    logic [N-1:0]  ovf;
    logic          final_acc;
    logic          col_en;
    logic [BW-1:0] rd_data;
    logic [DW-1:0] lane_v;

    assign final_acc = (state == DRAIN) && rd_valid && bus.RD_READY && (rd_ptr == RW'(N - 1));
    assign col_en    = (state != DRAIN) || final_acc;

    for (genvar j = 0; j < N; j++) begin : g_col
        obuf4_col u_col (
            .clk      (CLK),
            .rst      (RST),
            .en       (col_en),
            .clr      (final_acc),
            .vld      (bus.OVALID[j]),
            .din      (lane(bus.ODATA, j)),
            .rsel     (rd_ptr),
            .dout     (row_lane[j]),
            .full_nxt (full_nxt[j]),
            .ovf      (ovf[j])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            tile_done <= 1'b0;
            err_ovf   <= 1'b0;
            tag       <= '0;
        end else begin
            tile_done <= final_acc;
            if (|ovf) begin
                err_ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (|bus.OVALID) begin
                        state <= COLLECT;
                        tag   <= bus.ODST_i;
                    end
                end
                COLLECT: begin
                    if (&full_nxt) begin
                        state    <= DRAIN;
                        rd_valid <= 1'b1;
                        rd_ptr   <= '0;
                    end
                end
                DRAIN: begin
                    if (rd_valid && bus.RD_READY) begin
                        if (rd_ptr == RW'(N - 1)) begin
                            rd_ptr   <= '0;
                            rd_valid <= 1'b0;
                            // results arriving with the last accept open the next tile
                            if (|bus.OVALID) begin
                                state <= COLLECT;
                                tag   <= bus.ODST_i;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            rd_ptr <= rd_ptr + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        lane_v  = '0;
        for (int unsigned j = 0; j < N; j++) begin
            lane_v = row_lane[j];
`ifdef OBUF_RELU_EN
            if (lane_v[DW-1]) begin
                lane_v = '0;
            end
`endif
            if (rd_valid) begin
                rd_data[j*DW +: DW] = lane_v;
            end
        end
    end

    assign bus.RD_VALID  = rd_valid;
    assign bus.RD_DATA   = rd_data;
    assign bus.RD_ROW    = rd_ptr;
    assign bus.ODST_o    = tag;
    assign bus.BUSY      = (state != IDLE);
    assign bus.TILE_DONE = tile_done;
    assign bus.ERR_OVF   = err_ovf;

endmodule
